// File: rtl/rf_wr_arbiter_pkg.sv
// Shared constants and the queued write-entry type for the register-file
// write-port arbiter.
package rf_wr_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [REG_AW-1:0] rw;
    logic [DATA_W-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// In-order queue of long-latency register writes, with per-slot valid bits
// and a flat destination vector for the pending-write decode.
module rf_wr_fifo
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  wr_entry_t               din,
  output wr_entry_t               head,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH-1:0]        ent_valid,
  output logic [DEPTH*REG_AW-1:0] ent_rw
);
  wr_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [DEPTH-1:0] valid;

  assign full = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head = mem[rd_ptr];
  assign ent_valid = valid;

  always_comb begin
    ent_rw = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rw[i*REG_AW +: REG_AW] = mem[i].rw;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Push and pop never hit the same slot: pop needs a non-empty queue and
  // push needs a non-full one, so the pointers differ whenever both fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        valid[rd_ptr] <= 1'b0;
      end
      if (push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB stage has absolute priority, a queued
// long-latency port drains in idle cycles. Optional macro: RF_ARB_WAW_CHK_EN.
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                A_WrEn,
  input  logic [REG_AW-1:0]   A_Rw,
  input  logic [DATA_W-1:0]   A_busW,
  input  logic                B_Valid,
  output logic                B_Ready,
  input  logic [REG_AW-1:0]   B_Rw,
  input  logic [DATA_W-1:0]   B_busW,
  input  logic                R31Wr,
  input  logic [REG_AW-1:0]   Ra,
  input  logic [REG_AW-1:0]   Rb,
  output logic                WrEn,
  output logic [REG_AW-1:0]   Rw,
  output logic [DATA_W-1:0]   busW,
  output logic                BusyA,
  output logic                BusyB,
  output logic [31:0]         Pending,
  output logic                WawErr
);
  // B handshake: a beat transfers on a posedge where B_Valid and B_Ready are
  // both high; B_Ready depends only on registered occupancy (never on a pop).
  wr_entry_t head;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic r31_block;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH*REG_AW-1:0] ent_rw;

  assign B_Ready = !full;
  assign push = B_Valid && B_Ready && (B_Rw != REG_ZERO);
  assign r31_block = (head.rw == REG_RA) && R31Wr;
  assign pop = !A_WrEn && !empty && !r31_block;

  rf_wr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(Clk),
    .reset(Reset),
    .push(push),
    .pop(pop),
    .din('{rw: B_Rw, data: B_busW}),
    .head(head),
    .full(full),
    .empty(empty),
    .ent_valid(ent_valid),
    .ent_rw(ent_rw)
  );

  always_comb begin
    WrEn = 1'b0;
    Rw = REG_ZERO;
    busW = '0;
    if (A_WrEn) begin
      WrEn = 1'b1;
      Rw = A_Rw;
      busW = A_busW;
    end else if (pop) begin
      WrEn = 1'b1;
      Rw = head.rw;
      busW = head.data;
    end
  end

  always_comb begin
    Pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) Pending[ent_rw[i*REG_AW +: REG_AW]] = 1'b1;
    end
    Pending[0] = 1'b0;
  end

  assign BusyA = (Ra != REG_ZERO) && Pending[Ra];
  assign BusyB = (Rb != REG_ZERO) && Pending[Rb];

`ifdef RF_ARB_WAW_CHK_EN
  // A WB write to a register with an older queued B write would later be
  // overwritten by that stale value; flag it until reset.
  always_ff @(posedge Clk) begin
    if (Reset) WawErr <= 1'b0;
    else if (A_WrEn && (A_Rw != REG_ZERO) && Pending[A_Rw]) WawErr <= 1'b1;
  end
`else
  assign WawErr = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected rf writes go into a queue that a
// negedge monitor drains whenever the DUT asserts WrEn.
module tb_rf_wr_arbiter;
  logic        clk;
  logic        reset;
  logic        a_wren;
  logic [4:0]  a_rw;
  logic [31:0] a_busw;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rw;
  logic [31:0] b_busw;
  logic        r31wr;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        wren;
  logic [4:0]  rw;
  logic [31:0] busw;
  logic        busy_a;
  logic        busy_b;
  logic [31:0] pending;
  logic        waw_err;

  logic [36:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic exp_waw;

  rf_wr_arbiter dut (
    .Clk(clk), .Reset(reset),
    .A_WrEn(a_wren), .A_Rw(a_rw), .A_busW(a_busw),
    .B_Valid(b_valid), .B_Ready(b_ready), .B_Rw(b_rw), .B_busW(b_busw),
    .R31Wr(r31wr), .Ra(ra), .Rb(rb),
    .WrEn(wren), .Rw(rw), .busW(busw),
    .BusyA(busy_a), .BusyB(busy_b), .Pending(pending), .WawErr(waw_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && wren) begin
      logic [36:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wr: got rw=%0d data=%h, none expected", rw, busw);
      end else begin
        e = exp_q.pop_front();
        if ({rw, busw} !== e) begin
          failures++;
          $display("FAIL wr_data: got rw=%0d data=%h, expected rw=%0d data=%h",
                   rw, busw, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: set one cycle of inputs and record the hand-computed rf write
  task automatic set_in(input logic ae, input logic [4:0] arw, input logic [31:0] ad,
                        input logic bv, input logic [4:0] brw, input logic [31:0] bd,
                        input logic r31, input logic ew, input logic [4:0] erw,
                        input logic [31:0] ed);
    a_wren = ae; a_rw = arw; a_busw = ad;
    b_valid = bv; b_rw = brw; b_busw = bd;
    r31wr = r31;
    if (ew) exp_q.push_back({erw, ed});
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ew, input logic [4:0] erw, input logic [31:0] ed);
    set_in(0, 0, 0, 0, 0, 0, 0, ew, erw, ed);
  endtask

  initial begin
`ifdef RF_ARB_WAW_CHK_EN
    exp_waw = 1'b1;
`else
    exp_waw = 1'b0;
`endif
    reset = 1'b1; ra = 0; rb = 0;
    idle(0, 0, 0);
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_b_ready", {31'd0, b_ready}, 32'd1);
    check("rst_pending", pending, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
    check("rst_waw", {31'd0, waw_err}, 32'd0);

    // 1: A write passes straight through
    set_in(1, 5, 32'h1234, 0, 0, 0, 0, 1, 5, 32'h1234);
    check("t1_b_ready", {31'd0, b_ready}, 32'd1);
    check("t1_pending", pending, 32'd0);
    step();

    // 2: B queues behind busy A, drains in order when A idles
    set_in(1, 6, 32'h11, 1, 8, 32'hA, 0, 1, 6, 32'h11);
    step();
    ra = 8;
    set_in(1, 7, 32'h22, 1, 9, 32'hB, 0, 1, 7, 32'h22);
    check("t2_pending_r8", pending, 32'h100);
    check("t2_busy_a", {31'd0, busy_a}, 32'd1);
    step();
    rb = 9;
    idle(1, 8, 32'hA);
    check("t2_pending_r8r9", pending, 32'h300);
    check("t2_busy_ab", {30'd0, busy_a, busy_b}, 32'd3);
    step();
    idle(1, 9, 32'hB);
    check("t2_pending_r9", pending, 32'h200);
    step();
    ra = 0; rb = 0;
    idle(0, 0, 0);
    check("t2_pending_clr", pending, 32'd0);

    // 3: fill the queue, backpressure, then simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i), 0, 1, 1, 32'(i));
      step();
    end
    set_in(1, 2, 32'h2, 1, 20, 32'h200, 0, 1, 2, 32'h2);
    check("t3_full_ready", {31'd0, b_ready}, 32'd0);
    check("t3_full_pending", pending, 32'h3C00);
    step();
    set_in(0, 0, 0, 1, 20, 32'h200, 0, 1, 10, 32'h100);
    check("t3_held_ready", {31'd0, b_ready}, 32'd0);
    step();
    set_in(0, 0, 0, 1, 20, 32'h200, 0, 1, 11, 32'h101);
    check("t3_ready_after_pop", {31'd0, b_ready}, 32'd1);
    check("t3_pending_cnt3", pending, 32'h3800);
    step();
    idle(1, 12, 32'h102);
    check("t3_pending_pushpop", pending, 32'h103000);
    step();
    idle(1, 13, 32'h103); step();
    idle(1, 20, 32'h200); step();
    idle(0, 0, 0);
    check("t3_pending_clr", pending, 32'd0);

    // 4: r31 head held while the link write is on the port
    set_in(1, 3, 32'h33, 1, 31, 32'h31F, 0, 1, 3, 32'h33);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("t4_r31_hold", {31'd0, wren}, 32'd0);
    check("t4_pending_r31", pending, 32'h8000_0000);
    step();
    idle(1, 31, 32'h31F);
    step();
    idle(0, 0, 0);
    check("t4_pending_clr", pending, 32'd0);

    // 5: writes to r0 are accepted and dropped
    set_in(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0);
    check("t5_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    idle(0, 0, 0);
    check("t5_wren", {31'd0, wren}, 32'd0);
    check("t5_pending", pending, 32'd0);
    step();

    // 6: WB overtaking a queued write to the same register
    set_in(1, 2, 32'h44, 1, 12, 32'hC, 0, 1, 2, 32'h44);
    step();
    set_in(1, 12, 32'h55, 0, 0, 0, 0, 1, 12, 32'h55);
    check("t6_waw_before", {31'd0, waw_err}, 32'd0);
    step();
    idle(1, 12, 32'hC);
    check("t6_waw_set", {31'd0, waw_err}, {31'd0, exp_waw});
    step();
    idle(0, 0, 0);
    check("t6_waw_sticky", {31'd0, waw_err}, {31'd0, exp_waw});

    // reset discards queued entries and clears the flag
    set_in(1, 4, 32'h66, 1, 14, 32'hE, 0, 1, 4, 32'h66);
    step();
    reset = 1'b1;
    idle(0, 0, 0);
    step();
    reset = 1'b0;
    #1;
    check("rst2_pending", pending, 32'd0);
    check("rst2_b_ready", {31'd0, b_ready}, 32'd1);
    check("rst2_waw", {31'd0, waw_err}, 32'd0);
    check("rst2_wren", {31'd0, wren}, 32'd0);
    step(); step();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
